clk_gate_ctrl: RTL and testbench



---
 rtl/clk_gate_pkg.sv | 24 ++
 rtl/clk_gate_idle_timer.sv | 45 ++++
 rtl/clk_gate_ctrl.sv | 166 ++++++++++++++++
 tb/tb_clk_gate_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gate_pkg.sv
// Shared types and defaults for the gated-clock domain controller.
//   state_t          : controller state encoding, exposed on the debug port
//   DEF_IDLE_CYCLES  : default request-free cycles in ON before gating off
//   DEF_GATE_LAT     : default gating-cell enable-to-clock latency
//   WAKE_CNT_W       : width of the wake event counter
//   sat_inc()        : saturating increment for the wake counter
package clk_gate_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    WAKE  = 2'b01,
    ON    = 2'b10,
    DRAIN = 2'b11
  } state_t;

  localparam int DEF_IDLE_CYCLES = 16;
  localparam int DEF_GATE_LAT    = 2;
  localparam int WAKE_CNT_W      = 16;

  function automatic logic [WAKE_CNT_W-1:0] sat_inc(input logic [WAKE_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/clk_gate_idle_timer.sv
// Loadable up/down counter with clear and terminal-count compare.
// Used both as the ON-state idle counter (counts up) and as the gating
// latency counter (loaded, then counts down).
//   clk, rst  : clock, async active-high reset (count -> 0)
//   clr       : synchronous clear (highest priority)
//   load      : load load_val
//   inc / dec : count up / down; up saturates at all-ones, down stops at 1
//   tc_val    : terminal-count value
//   tc        : high while the count equals tc_val
module clk_gate_idle_timer
  import clk_gate_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (inc && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (dec && (cnt_q > CNT_W'(1))) begin
      // The latency count is consumed at 1, so it never needs to go lower.
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Idle-driven enable controller for one gated clock domain.
// Drives the enable of a two-stage clock-gating cell, waits out the cell's
// enable pipeline before declaring the clock running, and gates the domain
// off after IDLE_CYCLES request-free cycles.
//   clk, rst   : free-running clock, async active-high reset
//   req        : per-requester clock request (level)
//   force_on   : debug override, holds the domain on
//   gate_en    : registered enable to the gating cell
//   clk_active : registered, gated clock guaranteed running
//   ack        : req[i] & clk_active
//   wake_count : saturating count of OFF->WAKE transitions
//   state      : controller state, for debug observation
//
// Request/ack handshake: req[i] is a level held by requester i for as long
// as it needs the clock; ack[i] is high in every cycle where req[i] is high
// and the gated clock is guaranteed running. There is no per-transfer
// acceptance: dropping req[i] simply withdraws the request.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int GATE_LAT    = DEF_GATE_LAT,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic                  force_on,
  output logic                  gate_en,
  output logic                  clk_active,
  output logic [NUM_REQ-1:0]    ack,
  output logic [WAKE_CNT_W-1:0] wake_count,
  output state_t                state
);

  state_t                state_q, state_d;
  logic                  gate_en_q, gate_en_d;
  logic                  clk_active_q, clk_active_d;
  logic [WAKE_CNT_W-1:0] wake_cnt_q;
  logic                  wake_inc;
  logic                  any_req;
  logic                  idle_clr, idle_inc, idle_tc;
  logic                  lat_load, lat_dec, lat_tc;

  assign any_req = (|req) | force_on;

  // Counts request-free edges spent in ON; tc marks the last one allowed.
  clk_gate_idle_timer #(.CNT_W(CNT_W)) u_idle (
    .clk      (clk),
    .rst      (rst),
    .clr      (idle_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (idle_inc),
    .dec      (1'b0),
    .tc_val   (CNT_W'(IDLE_CYCLES - 1)),
    .tc       (idle_tc)
  );

  // Tracks the gating cell's enable pipeline on both wake and drain.
  clk_gate_idle_timer #(.CNT_W(CNT_W)) u_lat (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .load     (lat_load),
    .load_val (CNT_W'(GATE_LAT)),
    .inc      (1'b0),
    .dec      (lat_dec),
    .tc_val   (CNT_W'(1)),
    .tc       (lat_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= OFF;
      gate_en_q    <= 1'b0;
      clk_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_en_q    <= gate_en_d;
      clk_active_q <= clk_active_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gate_en_d    = gate_en_q;
    clk_active_d = clk_active_q;
    idle_clr     = 1'b0;
    idle_inc     = 1'b0;
    lat_load     = 1'b0;
    lat_dec      = 1'b0;
    wake_inc     = 1'b0;
    case (state_q)
      OFF: begin
        gate_en_d    = 1'b0;
        clk_active_d = 1'b0;
        if (any_req) begin
          state_d   = WAKE;
          gate_en_d = 1'b1;
          lat_load  = 1'b1;
          wake_inc  = 1'b1;
        end
      end
      WAKE: begin
        // Never aborted: a request dropped here still lands in ON and idles out.
        gate_en_d    = 1'b1;
        clk_active_d = 1'b0;
        if (lat_tc) begin
          state_d      = ON;
          clk_active_d = 1'b1;
          idle_clr     = 1'b1;
        end else begin
          lat_dec = 1'b1;
        end
      end
      ON: begin
        gate_en_d    = 1'b1;
        clk_active_d = 1'b1;
        if (any_req) begin
          // A request on the timeout edge wins over the timeout.
          idle_clr = 1'b1;
        end else if (idle_tc) begin
          state_d      = DRAIN;
          gate_en_d    = 1'b0;
          clk_active_d = 1'b0;
          idle_clr     = 1'b1;
          lat_load     = 1'b1;
        end else begin
          idle_inc = 1'b1;
        end
      end
      DRAIN: begin
        // Requests are ignored here; being levels, OFF picks them up next.
        gate_en_d    = 1'b0;
        clk_active_d = 1'b0;
        if (lat_tc) begin
          state_d = OFF;
        end else begin
          lat_dec = 1'b1;
        end
      end
      default: begin
        state_d      = OFF;
        gate_en_d    = 1'b0;
        clk_active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wake_cnt_q <= '0;
    end else if (wake_inc) begin
      wake_cnt_q <= sat_inc(wake_cnt_q);
    end
  end

  assign gate_en    = gate_en_q;
  assign clk_active = clk_active_q;
  assign ack        = req & {NUM_REQ{clk_active_q}};
  assign wake_count = wake_cnt_q;
  assign state      = state_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
module tb_clk_gate_ctrl;
  import clk_gate_pkg::*;

  localparam int NUM_REQ     = 4;
  localparam int IDLE_CYCLES = 16;
  localparam int GATE_LAT    = 2;

  // ---------------- clock / reset ----------------
  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req = '0;
  logic                  force_on = 1'b0;
  logic                  gate_en;
  logic                  clk_active;
  logic [NUM_REQ-1:0]    ack;
  logic [WAKE_CNT_W-1:0] wake_count;
  state_t                state;

  always #5 clk = ~clk;

  clk_gate_ctrl #(
    .NUM_REQ     (NUM_REQ),
    .IDLE_CYCLES (IDLE_CYCLES),
    .GATE_LAT    (GATE_LAT),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .force_on   (force_on),
    .gate_en    (gate_en),
    .clk_active (clk_active),
    .ack        (ack),
    .wake_count (wake_count),
    .state      (state)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- reference model ----------------
  // Timeline view: the domain is either powered or not. Once woken at edge w,
  // the clock counts as running from edge w+GATE_LAT. It powers down at the
  // edge that completes IDLE_CYCLES request-free edges after the last busy
  // edge, and can be woken again only GATE_LAT+1 edges after that.
  int   t;
  bit   powered;
  int   on_t;
  int   last_busy;
  int   off_t;
  logic [WAKE_CNT_W-1:0] m_wakes;

  task automatic model_reset();
    t = 0; powered = 0; on_t = 0; last_busy = 0; off_t = 0; m_wakes = '0;
  endtask

  task automatic model_edge();
    bit a;
    a = (|req) || force_on;
    t++;
    if (!powered) begin
      if (t >= off_t && a) begin
        powered   = 1;
        on_t      = t + GATE_LAT;
        last_busy = on_t;
        if (m_wakes != 16'hFFFF) m_wakes = m_wakes + 1'b1;
      end
    end else if (t > on_t) begin
      if (a) last_busy = t;
      else if (t - last_busy == IDLE_CYCLES) begin
        powered = 0;
        off_t   = t + GATE_LAT + 1;
      end
    end
  endtask

  // ---------------- driver ----------------
  // One clock edge: advance the model, then compare DUT outputs 1 time unit later.
  task automatic step();
    bit m_ca;
    @(posedge clk);
    model_edge();
    #1;
    m_ca = powered && (t >= on_t);
    exp_q.push_back(32'(powered));
    exp_q.push_back(32'(m_ca));
    exp_q.push_back(32'(req & {NUM_REQ{m_ca}}));
    exp_q.push_back(32'(m_wakes));
    chk("model_gate_en",    32'(gate_en),    exp_q.pop_front());
    chk("model_clk_active", 32'(clk_active), exp_q.pop_front());
    chk("model_ack",        32'(ack),        exp_q.pop_front());
    chk("model_wake_count", 32'(wake_count), exp_q.pop_front());
    if (clk_active && !gate_en) chk("active_without_enable", 32'(clk_active), 32'd0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NUM_REQ-1:0] req;
    logic               force_on;
    logic               exp_ge;
    logic               exp_ca;
    logic [NUM_REQ-1:0] exp_ack;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    tbl[1] = '{4'b0001, 1'b0, 1'b1, 1'b0, 4'b0000};
    tbl[2] = '{4'b0001, 1'b0, 1'b1, 1'b0, 4'b0000};
    tbl[3] = '{4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001};
    tbl[4] = '{4'b0011, 1'b0, 1'b1, 1'b1, 4'b0011};
    tbl[5] = '{4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000};

    // Reset held for 10 cycles with no requests.
    rst = 1'b1; req = '0; force_on = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_gate_en",    32'(gate_en),    32'd0);
    chk("rst_clk_active", 32'(clk_active), 32'd0);
    chk("rst_ack",        32'(ack),        32'd0);
    chk("rst_wake_count", 32'(wake_count), 32'd0);
    chk("rst_state",      32'(state),      32'(OFF));
    rst = 1'b0;
    model_reset();

    // Wake-up latency from the table.
    for (int i = 0; i < 6; i++) begin
      req = tbl[i].req; force_on = tbl[i].force_on;
      step();
      chk($sformatf("tbl%0d_gate_en", i),    32'(gate_en),    32'(tbl[i].exp_ge));
      chk($sformatf("tbl%0d_clk_active", i), 32'(clk_active), 32'(tbl[i].exp_ca));
      chk($sformatf("tbl%0d_ack", i),        32'(ack),        32'(tbl[i].exp_ack));
    end
    chk("wake_count_1", 32'(wake_count), 32'd1);

    // Idle timeout: exactly IDLE_CYCLES request-free edges.
    req = '0; force_on = 1'b0;
    steps(IDLE_CYCLES - 1);
    chk("idle_before_timeout_ge", 32'(gate_en), 32'd1);
    step();
    chk("idle_timeout_ge", 32'(gate_en),    32'd0);
    chk("idle_timeout_ca", 32'(clk_active), 32'd0);
    chk("idle_timeout_st", 32'(state),      32'(DRAIN));
    steps(GATE_LAT);
    chk("drain_to_off", 32'(state), 32'(OFF));

    // Re-request, dropped during WAKE: still reaches ON.
    req = 4'b0001;
    step();
    chk("wake_count_2", 32'(wake_count), 32'd2);
    chk("rewake_state", 32'(state),      32'(WAKE));
    req = '0;
    steps(GATE_LAT);
    chk("wake_not_aborted", 32'(state), 32'(ON));

    // Request on the exact timeout edge keeps the domain on and restarts the count.
    steps(IDLE_CYCLES - 1);
    req = 4'b0010;
    step();
    chk("timeout_edge_req_ge", 32'(gate_en), 32'd1);
    chk("timeout_edge_req_st", 32'(state),   32'(ON));
    req = '0;
    steps(IDLE_CYCLES - 1);
    chk("idle_restarted_ge", 32'(gate_en), 32'd1);
    step();
    chk("idle_restarted_off", 32'(gate_en), 32'd0);

    // Request raised during DRAIN is held off, then serviced.
    req = 4'b0100;
    step();
    chk("drain_req_ack", 32'(ack),   32'd0);
    chk("drain_req_st",  32'(state), 32'(DRAIN));
    step();
    chk("drain_end_st",  32'(state), 32'(OFF));
    chk("drain_end_ack", 32'(ack),   32'd0);
    step();
    chk("drain_rewake_st", 32'(state), 32'(WAKE));
    steps(GATE_LAT - 1);
    chk("drain_rewake_ack0", 32'(ack), 32'd0);
    step();
    chk("drain_rewake_ack", 32'(ack), 32'b0100);

    // force_on holds the domain on with no requests.
    req = '0; force_on = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (i % 25 == 24) chk($sformatf("force_on_%0d", i), 32'(state), 32'(ON));
    end
    chk("force_on_ge", 32'(gate_en), 32'd1);

    // Async reset mid-ON drops the enable before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ge", 32'(gate_en),    32'd0);
    chk("async_rst_ca", 32'(clk_active), 32'd0);
    chk("async_rst_wc", 32'(wake_count), 32'd0);
    force_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Wake counter saturation from a preloaded near-full value.
    force dut.wake_cnt_q = 16'hFFFE;
    #1;
    release dut.wake_cnt_q;
    m_wakes = 16'hFFFE;
    for (int c = 0; c < 3; c++) begin
      req = 4'b1000;
      step();
      chk($sformatf("sat_wake%0d", c), 32'(wake_count), 32'hFFFF);
      req = '0;
      steps(GATE_LAT + IDLE_CYCLES + GATE_LAT + 1);
    end

    // Randomized traffic against the model, in dense/sparse/quiet phases.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      int mode;
      mode = (i / 150) % 3;
      force_on = ($urandom_range(0, 99) == 0);
      case (mode)
        0:       req = ($urandom_range(0, 1) == 0) ? NUM_REQ'($urandom_range(0, 15)) : '0;
        1:       req = ($urandom_range(0, 9) == 0) ? NUM_REQ'($urandom_range(0, 15)) : '0;
        default: req = ($urandom_range(0, 39) == 0) ? NUM_REQ'($urandom_range(1, 15)) : '0;
      endcase
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
